// File: rtl/ov7670_stream_cfg_master.sv
// AXI4-Lite bring-up sequencer: writes a table of words to consecutive registers,
// reads each one back, and retries an entry a bounded number of times before failing.
module ov7670_stream_cfg_master #(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter int                            NUM_REGS           = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
    parameter int                            MAX_RETRY          = 3,
    parameter int                            TIMEOUT            = 255
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic                              start,
    output logic [3:0]                        tbl_idx,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     tbl_data,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [3:0]                        err_idx,
    output logic [3:0]                        dbg_state_o,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_WR, S_WAIT_B, S_RD, S_WAIT_R, S_CHECK, S_DONE, S_FAIL
    } state_t;

    state_t                          state_q;
    logic [3:0]                      idx_q;
    logic [RW-1:0]                   retry_q;
    logic [CW-1:0]                   cnt_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]                      rresp_q;
    logic                            awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
    logic                            busy_q, done_q, error_q;
    logic [3:0]                      err_idx_q;

    logic wr_both_d, tmo_d, check_ok_d, fail_d;

    // A channel counts as finished once its valid has dropped or is being accepted now.
    always_comb begin
        wr_both_d  = (!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY);
        tmo_d      = (cnt_q == CW'(TIMEOUT));
        check_ok_d = (rresp_q == 2'b00) && (rdata_q == wdata_q);
        fail_d     = 1'b0;
        case (state_q)
            S_WR:     fail_d = tmo_d && !wr_both_d;
            S_WAIT_B: fail_d = M_AXI_BVALID ? (M_AXI_BRESP != 2'b00) : tmo_d;
            S_RD:     fail_d = tmo_d && !M_AXI_ARREADY;
            S_WAIT_R: fail_d = tmo_d && !M_AXI_RVALID;
            S_CHECK:  fail_d = !check_ok_d;
            default:  fail_d = 1'b0;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            retry_q   <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        error_q <= 1'b0;
                        idx_q   <= '0;
                        retry_q <= '0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    wdata_q   <= tbl_data;
                    addr_q    <= BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx_q, 2'b00});
                    awvalid_q <= 1'b1;
                    wvalid_q  <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= S_WR;
                end
                S_WR: begin
                    if (awvalid_q && M_AXI_AWREADY) awvalid_q <= 1'b0;
                    if (wvalid_q && M_AXI_WREADY)   wvalid_q  <= 1'b0;
                    if (wr_both_d) begin
                        bready_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (M_AXI_BVALID) begin
                        bready_q <= 1'b0;
                        if (M_AXI_BRESP == 2'b00) begin
                            arvalid_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= S_WAIT_R;
                    end
                end
                S_WAIT_R: begin
                    if (M_AXI_RVALID) begin
                        rready_q <= 1'b0;
                        rdata_q  <= M_AXI_RDATA;
                        rresp_q  <= M_AXI_RRESP;
                        cnt_q    <= '0;
                        state_q  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (check_ok_d) begin
                        cnt_q <= '0;
                        if (idx_q == 4'(NUM_REGS - 1)) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            retry_q <= '0;
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                S_FAIL: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            // A failed attempt overrides the normal transition and abandons the bus.
            if (fail_d) begin
                awvalid_q <= 1'b0;
                wvalid_q  <= 1'b0;
                arvalid_q <= 1'b0;
                bready_q  <= 1'b0;
                rready_q  <= 1'b0;
                cnt_q     <= '0;
                if (retry_q < RW'(MAX_RETRY)) begin
                    retry_q <= retry_q + 1'b1;
                    state_q <= S_LOAD;
                end else begin
                    err_idx_q <= idx_q;
                    error_q   <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= S_FAIL;
                end
            end
        end
    end

    assign tbl_idx       = idx_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_idx       = err_idx_q;
    assign dbg_state_o   = state_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_ov7670_stream_cfg_master.sv
// Directed bench: AXI4-Lite memory slave with fault injection, write/read logs
// compared against hand-written expected address/data lists.
module tb_ov7670_stream_cfg_master;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  tbl_idx;
    logic [31:0] tbl_data;
    logic        busy, done, error;
    logic [3:0]  err_idx, dbg_state;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    int checks = 0;
    int errors = 0;

    // ---------------- clock ----------------
    always #5 ACLK = ~ACLK;

    // ---------------- table source ----------------
    logic [31:0] tbl [0:3];
    initial begin
        tbl[0] = 32'h0101FFFF;
        tbl[1] = 32'habcd0001;
        tbl[2] = 32'hdead0011;
        tbl[3] = 32'hbeef0011;
    end
    assign tbl_data = (tbl_idx < 4'd4) ? tbl[tbl_idx[1:0]] : 32'h0;

    ov7670_stream_cfg_master dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start),
        .tbl_idx(tbl_idx), .tbl_data(tbl_data),
        .busy(busy), .done(done), .error(error), .err_idx(err_idx),
        .dbg_state_o(dbg_state),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    // ---------------- slave configuration (written only by the main initial) ----------------
    int          aw_delay = 0;
    int          w_delay = 0;
    bit          ar_block = 1'b0;
    logic [31:0] bad_b_addr = 32'hFFFF_FFFF;
    int          bad_b_budget = 0;
    bit          corrupt_en = 1'b0;
    logic [31:0] corrupt_addr = 32'h0;

    // ---------------- slave + monitor state ----------------
    int          aw_cnt, w_cnt, bad_b_used;
    bit          got_aw, got_w, got_ar, bvalid_r, rvalid_r;
    logic [31:0] aw_l, w_l, ar_l, rdata_r;
    logic [1:0]  bresp_r;
    logic [31:0] mem [0:15];
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [31:0] rd_addr_log[$];
    int          done_cnt, solo_cnt, drop_viol, aw_hs_cnt, w_hs_cnt, cur_run, first_run;
    bit          prev_aw_pend, prev_w_pend;

    assign M_AXI_AWREADY = (aw_cnt >= aw_delay);
    assign M_AXI_WREADY  = (w_cnt >= w_delay);
    assign M_AXI_ARREADY = !ar_block;
    assign M_AXI_BVALID  = bvalid_r;
    assign M_AXI_BRESP   = bresp_r;
    assign M_AXI_RVALID  = rvalid_r;
    assign M_AXI_RDATA   = rdata_r;
    assign M_AXI_RRESP   = 2'b00;

    always @(posedge ACLK) begin
        if (ARESET) begin
            aw_cnt <= 0; w_cnt <= 0; bad_b_used <= 0;
            got_aw <= 1'b0; got_w <= 1'b0; got_ar <= 1'b0;
            bvalid_r <= 1'b0; rvalid_r <= 1'b0; bresp_r <= 2'b00;
            aw_l <= '0; w_l <= '0; ar_l <= '0; rdata_r <= '0;
            wr_addr_log.delete(); wr_data_log.delete(); rd_addr_log.delete();
            done_cnt <= 0; solo_cnt <= 0; drop_viol <= 0; aw_hs_cnt <= 0; w_hs_cnt <= 0;
            cur_run <= 0; first_run <= 0; prev_aw_pend <= 1'b0; prev_w_pend <= 1'b0;
        end else begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_l <= M_AXI_AWADDR; got_aw <= 1'b1; aw_cnt <= 0; aw_hs_cnt <= aw_hs_cnt + 1;
            end else if (M_AXI_AWVALID) aw_cnt <= aw_cnt + 1;
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                w_l <= M_AXI_WDATA; got_w <= 1'b1; w_cnt <= 0; w_hs_cnt <= w_hs_cnt + 1;
            end else if (M_AXI_WVALID) w_cnt <= w_cnt + 1;
            if (got_aw && got_w && !bvalid_r) begin
                mem[aw_l[5:2]] <= w_l;
                wr_addr_log.push_back(aw_l);
                wr_data_log.push_back(w_l);
                bvalid_r <= 1'b1;
                got_aw <= 1'b0; got_w <= 1'b0;
                if (aw_l == bad_b_addr && bad_b_used < bad_b_budget) begin
                    bresp_r <= 2'b10; bad_b_used <= bad_b_used + 1;
                end else bresp_r <= 2'b00;
            end
            if (bvalid_r && M_AXI_BREADY) bvalid_r <= 1'b0;
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                ar_l <= M_AXI_ARADDR; got_ar <= 1'b1; rd_addr_log.push_back(M_AXI_ARADDR);
            end
            if (got_ar && !rvalid_r) begin
                rvalid_r <= 1'b1;
                rdata_r  <= (corrupt_en && ar_l == corrupt_addr) ? 32'habcd0000 : mem[ar_l[5:2]];
                got_ar   <= 1'b0;
            end
            if (rvalid_r && M_AXI_RREADY) rvalid_r <= 1'b0;
            // bus-level monitor
            if (done) done_cnt <= done_cnt + 1;
            if (M_AXI_AWVALID ^ M_AXI_WVALID) solo_cnt <= solo_cnt + 1;
            if ((prev_aw_pend && !M_AXI_AWVALID) || (prev_w_pend && !M_AXI_WVALID))
                drop_viol <= drop_viol + 1;
            prev_aw_pend <= M_AXI_AWVALID && !M_AXI_AWREADY;
            prev_w_pend  <= M_AXI_WVALID && !M_AXI_WREADY;
            if (M_AXI_ARVALID) cur_run <= cur_run + 1;
            else if (cur_run != 0) begin
                if (first_run == 0) first_run <= cur_run;
                cur_run <= 0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [31:0] exp_q[$];

    task automatic check_log(input string tag, input logic [31:0] got_q[$], input logic [31:0] want_q[$]);
        check_eq({tag, "_len"}, 32'(got_q.size()), 32'(want_q.size()));
        for (int i = 0; i < want_q.size() && i < got_q.size(); i++)
            check_eq($sformatf("%s_%0d", tag, i), got_q[i], want_q[i]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        ARESET = 1'b1;
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic pulse_start(input string tag);
        @(negedge ACLK);
        start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        check_eq({tag, "_busy_rise"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge ACLK);
            n++;
        end
        check_eq({tag, "_finish_in_budget"}, 32'(busy), 32'd0);
        @(negedge ACLK);
    endtask

    task automatic clear_faults();
        aw_delay = 0; w_delay = 0; ar_block = 1'b0;
        bad_b_addr = 32'hFFFF_FFFF; bad_b_budget = 0;
        corrupt_en = 1'b0; corrupt_addr = 32'h0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        clear_faults();
        // reset state
        do_reset();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        check_eq("rst_err_idx", 32'(err_idx), 32'd0);
        check_eq("rst_tbl_idx", 32'(tbl_idx), 32'd0);
        check_eq("rst_handshake_outs",
                 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}), 32'd0);
        check_eq("rst_awaddr", M_AXI_AWADDR, 32'h0);
        check_eq("rst_araddr", M_AXI_ARADDR, 32'h0);
        check_eq("rst_wdata", M_AXI_WDATA, 32'h0);
        check_eq("const_prot_strb", 32'({M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB}), 32'h00F);

        // 1: ideal slave
        pulse_start("t1");
        wait_idle("t1", 300);
        check_eq("t1_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("t1_error", 32'(error), 32'd0);
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        check_log("t1_wr_addr", wr_addr_log, exp_q);
        exp_q = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};
        check_log("t1_wr_data", wr_data_log, exp_q);
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        check_log("t1_rd_addr", rd_addr_log, exp_q);

        // 2a: AWREADY delayed 3, WREADY immediate
        do_reset();
        aw_delay = 3; w_delay = 0;
        pulse_start("t2a");
        wait_idle("t2a", 400);
        check_eq("t2a_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("t2a_aw_hs", 32'(aw_hs_cnt), 32'd4);
        check_eq("t2a_w_hs", 32'(w_hs_cnt), 32'd4);
        check_eq("t2a_writes", 32'(wr_addr_log.size()), 32'd4);
        check_eq("t2a_solo_cycles", 32'(solo_cnt), 32'd12);
        check_eq("t2a_drop_viol", 32'(drop_viol), 32'd0);

        // 2b: the reverse
        do_reset();
        aw_delay = 0; w_delay = 3;
        pulse_start("t2b");
        wait_idle("t2b", 400);
        check_eq("t2b_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("t2b_aw_hs", 32'(aw_hs_cnt), 32'd4);
        check_eq("t2b_w_hs", 32'(w_hs_cnt), 32'd4);
        check_eq("t2b_solo_cycles", 32'(solo_cnt), 32'd12);
        check_eq("t2b_drop_viol", 32'(drop_viol), 32'd0);
        exp_q = '{32'hdead0011};
        check_eq("t2b_mem2", mem[2], exp_q[0]);

        // 3: one SLVERR on the write of entry 2
        clear_faults();
        do_reset();
        bad_b_addr = 32'h8; bad_b_budget = 1;
        pulse_start("t3");
        wait_idle("t3", 400);
        check_eq("t3_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("t3_error", 32'(error), 32'd0);
        exp_q = '{32'h0, 32'h4, 32'h8, 32'h8, 32'hC};
        check_log("t3_wr_addr", wr_addr_log, exp_q);
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        check_log("t3_rd_addr", rd_addr_log, exp_q);

        // 4: readback of entry 1 always corrupted
        clear_faults();
        do_reset();
        corrupt_en = 1'b1; corrupt_addr = 32'h4;
        pulse_start("t4");
        wait_idle("t4", 400);
        check_eq("t4_error", 32'(error), 32'd1);
        check_eq("t4_err_idx", 32'(err_idx), 32'd1);
        check_eq("t4_busy", 32'(busy), 32'd0);
        check_eq("t4_done_cnt", 32'(done_cnt), 32'd0);
        exp_q = '{32'h0, 32'h4, 32'h4, 32'h4, 32'h4};
        check_log("t4_wr_addr", wr_addr_log, exp_q);
        check_log("t4_rd_addr", rd_addr_log, exp_q);

        // 5: ARREADY stuck low -> read-address timeout on every attempt of entry 0
        clear_faults();
        do_reset();
        ar_block = 1'b1;
        pulse_start("t5");
        wait_idle("t5", 3000);
        check_eq("t5_error", 32'(error), 32'd1);
        check_eq("t5_err_idx", 32'(err_idx), 32'd0);
        check_eq("t5_done_cnt", 32'(done_cnt), 32'd0);
        check_eq("t5_writes", 32'(wr_addr_log.size()), 32'd4);
        check_eq("t5_reads", 32'(rd_addr_log.size()), 32'd0);
        check_eq("t5_arvalid_run_near_255", 32'(first_run >= 250 && first_run <= 260), 32'd1);
        check_eq("t5_arvalid_low", 32'(M_AXI_ARVALID), 32'd0);

        // error stays set until the next start clears it
        clear_faults();
        pulse_start("t5b");
        check_eq("t5b_error_cleared", 32'(error), 32'd0);
        wait_idle("t5b", 400);
        check_eq("t5b_error", 32'(error), 32'd0);

        // 6: reset while waiting on the read data of entry 2, then restart
        do_reset();
        pulse_start("t6");
        n = 0;
        while (!(M_AXI_RREADY && tbl_idx == 4'd2) && n < 300) begin
            @(negedge ACLK);
            n++;
        end
        check_eq("t6_reached_wait_r", 32'(M_AXI_RREADY && tbl_idx == 4'd2), 32'd1);
        ARESET = 1'b1;
        @(negedge ACLK);
        check_eq("t6_handshake_outs",
                 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_tbl_idx", 32'(tbl_idx), 32'd0);
        ARESET = 1'b0;
        @(negedge ACLK);
        pulse_start("t6r");
        wait_idle("t6r", 300);
        check_eq("t6r_done_cnt", 32'(done_cnt), 32'd1);
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        check_log("t6r_wr_addr", wr_addr_log, exp_q);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
